tiny_program_loader: RTL

- Writer-side companion to the tiny processor core: receives a framed byte stream and writes it into the core's 16×8 instruction memory.
- Fills unused locations with HLT, verifies an optional checksum, and holds the core in reset until a complete, valid program is loaded.
- Sits between the host/debug byte link and the instruction memory write port; drives the core's active-low reset.

---
 rtl/tiny_program_loader_if.sv | 33 +++
 rtl/tiny_program_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tiny_program_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tiny_program_loader_if                                     |
// | Description : Byte-stream input, instruction-memory write port and       |
// |               core control/status of the tiny program loader.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface tiny_program_loader_if #(
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rst_n;
    logic              load_done;
    logic              load_err;

    // Host / debug link side: supplies bytes, observes memory and status.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, load_done, load_err
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/tiny_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tiny_program_loader                                        |
// | Description : Loads a framed byte stream into the tiny core's 16x8       |
// |               instruction memory, pads with HLT and releases core reset. |
// |               Optional CSUM byte: define TINY_LOADER_CHECKSUM_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tiny_program_loader #(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  wire logic            clk,
    input  wire logic            rst,
    tiny_program_loader_if.slave bus
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
`ifdef TINY_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM = 3'd3;
`endif
    localparam logic [2:0] c_FILL = 3'd4;
    localparam logic [2:0] c_RUN  = 3'd5;
    localparam logic [2:0] c_ERR  = 3'd6;

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_core_rst_n;
    logic              r_load_done;
    logic              r_load_err;

    logic w_ready;
    logic w_accept;
    logic w_is_sync;
    logic w_last_data;
    logic w_bad_len;

`ifdef TINY_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_sum_ok;
    assign w_sum_ok = (8'(r_sum + bus.in_data) == 8'h00);
`endif

    assign w_ready     = !rst && (r_state != c_FILL);
    assign w_accept    = bus.in_valid && w_ready;
    assign w_is_sync   = (bus.in_data == SYNC_BYTE);
    assign w_last_data = (r_cnt == r_len - 1'b1);
    assign w_bad_len   = (bus.in_data == 8'h00) || (bus.in_data > 8'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_core_rst_n <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
`ifdef TINY_LOADER_CHECKSUM_EN
            r_sum        <= 8'h00;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept && w_is_sync) r_state <= c_LEN;
                end
                c_LEN: begin
                    if (w_accept) begin
                        if (w_bad_len) begin
                            r_state    <= c_ERR;
                            r_load_err <= 1'b1;
                        end else begin
                            r_len   <= bus.in_data[ADDR_W:0];
                            r_cnt   <= '0;
`ifdef TINY_LOADER_CHECKSUM_EN
                            r_sum   <= bus.in_data;
`endif
                            r_state <= c_DATA;
                        end
                    end
                end
                c_DATA: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= bus.in_data;
                        r_cnt       <= r_cnt + 1'b1;
`ifdef TINY_LOADER_CHECKSUM_EN
                        r_sum       <= r_sum + bus.in_data;
                        if (w_last_data) r_state <= c_CSUM;
`else
                        // Without a CSUM byte the last data byte ends the frame;
                        // its own write occupies the next cycle, so FILL starts after it.
                        if (w_last_data) begin
                            if (r_len == c_DEPTH) begin
                                r_state      <= c_RUN;
                                r_core_rst_n <= 1'b1;
                                r_load_done  <= 1'b1;
                            end else begin
                                r_state <= c_FILL;
                            end
                        end
`endif
                    end
                end
`ifdef TINY_LOADER_CHECKSUM_EN
                c_CSUM: begin
                    if (w_accept) begin
                        if (!w_sum_ok) begin
                            r_state    <= c_ERR;
                            r_load_err <= 1'b1;
                        end else if (r_cnt == c_DEPTH) begin
                            r_state      <= c_RUN;
                            r_core_rst_n <= 1'b1;
                            r_load_done  <= 1'b1;
                        end else begin
                            // First pad write issued here so it lands right after CSUM.
                            r_state     <= c_FILL;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_cnt[ADDR_W-1:0];
                            r_mem_wdata <= FILL_BYTE;
                            r_cnt       <= r_cnt + 1'b1;
                        end
                    end
                end
`endif
                c_FILL: begin
                    if (r_cnt == c_DEPTH) begin
                        r_state      <= c_RUN;
                        r_core_rst_n <= 1'b1;
                        r_load_done  <= 1'b1;
                    end else begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= FILL_BYTE;
                        r_cnt       <= r_cnt + 1'b1;
                    end
                end
                c_RUN: begin
                    if (w_accept && w_is_sync) begin
                        r_state      <= c_LEN;
                        r_core_rst_n <= 1'b0;
                        r_load_done  <= 1'b0;
                    end
                end
                c_ERR: begin
                    if (w_accept && w_is_sync) begin
                        r_state    <= c_LEN;
                        r_load_err <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.core_rst_n = r_core_rst_n;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;

endmodule
`default_nettype wire
